// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: sigma constants, 16-word state type, stream FSM
// states and the quarter-round helper used by the block core.
package chacha20_pkg;

   localparam logic [31:0] SIGMA0 = 32'h61707865;
   localparam logic [31:0] SIGMA1 = 32'h3320646e;
   localparam logic [31:0] SIGMA2 = 32'h79622d32;
   localparam logic [31:0] SIGMA3 = 32'h6b206574;

   // Sixteen 32-bit state words, word 0 first.
   typedef logic [0:15][31:0] chacha_state_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GEN    = 2'd1,
      STREAM = 2'd2,
      HALT   = 2'd3
   } stream_state_t;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
      return (x << n) | (x >> (6'd32 - {1'b0, n}));
   endfunction

   function automatic logic [0:3][31:0] quarter_round(input logic [0:3][31:0] v);
      logic [31:0] a, b, c, d;
      a = v[0];
      b = v[1];
      c = v[2];
      d = v[3];
      a = a + b; d = rotl(d ^ a, 5'd16);
      c = c + d; b = rotl(b ^ c, 5'd12);
      a = a + b; d = rotl(d ^ a, 5'd8);
      c = c + d; b = rotl(b ^ c, 5'd7);
      return {a, b, c, d};
   endfunction

endpackage

// File: rtl/chacha20_block.sv
// ChaCha20 block function core: one round per cycle, 20 rounds, then the
// feed-forward add. Deliberately unresettable; a new start aborts any block in flight.
module chacha20_block
   import chacha20_pkg::*;
(
   input  logic          clk,
   input  logic          start,
   input  chacha_state_t state_in,
   output chacha_state_t state_out,
   output logic          done
);

   chacha_state_t    work;
   chacha_state_t    init;
   chacha_state_t    rnd_out;
   logic [4:0]       rnd;
   logic             run;
   logic [3:0]       ia, ib, ic, id;
   logic [0:3][31:0] qv;

   // Even rounds work on columns, odd rounds on diagonals.
   always_comb begin
      rnd_out = work;
      ia = '0;
      ib = '0;
      ic = '0;
      id = '0;
      qv = '0;
      for (int unsigned q = 0; q < 4; q++) begin
         ia = 4'(q);
         if (rnd[0]) begin
            ib = 4'(4 + ((q + 1) % 4));
            ic = 4'(8 + ((q + 2) % 4));
            id = 4'(12 + ((q + 3) % 4));
         end else begin
            ib = 4'(4 + q);
            ic = 4'(8 + q);
            id = 4'(12 + q);
         end
         qv = quarter_round({work[ia], work[ib], work[ic], work[id]});
         rnd_out[ia] = qv[0];
         rnd_out[ib] = qv[1];
         rnd_out[ic] = qv[2];
         rnd_out[id] = qv[3];
      end
   end

   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (start) begin
         work <= state_in;
         init <= state_in;
         rnd  <= '0;
         run  <= 1'b1;
      end else if (run) begin
         work <= rnd_out;
         rnd  <= rnd + 5'd1;
         if (rnd == 5'd19) begin
            run  <= 1'b0;
            done <= 1'b1;
            for (int unsigned i = 0; i < 16; i++) begin
               state_out[4'(i)] <= rnd_out[4'(i)] + init[4'(i)];
            end
         end
      end
   end

endmodule

// File: rtl/chacha20_stream.sv
// ChaCha20 stream encryptor: XORs a 32-bit word stream with the keystream,
// regenerating blocks on demand. Optional macro CHACHA20_STREAM_WORD_CNT_EN adds word_cnt.
module chacha20_stream
   import chacha20_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic [31:0]  ctr_init,
   input  logic         load,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_data,
   output logic         busy,
   output logic         ctr_err
`ifdef CHACHA20_STREAM_WORD_CNT_EN
   ,
   output logic [63:0]  word_cnt
`endif
);

   stream_state_t state, state_nxt;
   chacha_state_t ks, blk_in, blk_out;
   logic [255:0]  key_r;
   logic [95:0]   nonce_r;
   logic [31:0]   ctr;
   logic [3:0]    idx;
   logic          start, start_nxt;
   logic          pending, pending_nxt;
   logic          done, blk_done;
   logic          in_xfer, out_xfer;
   logic          ks_load, ctr_inc, err_set;

   always_comb begin
      blk_in[0] = SIGMA0;
      blk_in[1] = SIGMA1;
      blk_in[2] = SIGMA2;
      blk_in[3] = SIGMA3;
      for (int unsigned i = 0; i < 8; i++) blk_in[4'(4 + i)] = key_r[32*i +: 32];
      blk_in[12] = ctr;
      for (int unsigned j = 0; j < 3; j++) blk_in[4'(13 + j)] = nonce_r[32*j +: 32];
   end

   chacha20_block u_block (
      .clk       (clk),
      .start     (start),
      .state_in  (blk_in),
      .state_out (blk_out),
      .done      (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         start   <= 1'b0;
         pending <= 1'b0;
      end else begin
         state   <= state_nxt;
         start   <= start_nxt;
         pending <= pending_nxt;
      end
   end

   // done is only trusted once the start pulse has been taken by the core,
   // so a completion left over from an aborted block can never be accepted.
   always_comb begin
      in_ready    = (state == STREAM) && (!out_valid || out_ready);
      in_xfer     = in_valid && in_ready;
      out_xfer    = out_valid && out_ready;
      blk_done    = (state == GEN) && !start && done;
      busy        = (state == GEN) || (state == STREAM);
      state_nxt   = state;
      start_nxt   = 1'b0;
      pending_nxt = pending;
      ks_load     = 1'b0;
      ctr_inc     = 1'b0;
      err_set     = 1'b0;
      case (state)
         GEN: begin
            if (blk_done) begin
               if (pending) begin
                  pending_nxt = 1'b0;
                  start_nxt   = 1'b1;
               end else begin
                  ks_load   = 1'b1;
                  state_nxt = STREAM;
               end
            end
         end
         STREAM: begin
            if (in_xfer && idx == 4'd15) begin
               if (ctr == '1) begin
                  err_set   = 1'b1;
                  state_nxt = HALT;
               end else begin
                  ctr_inc   = 1'b1;
                  start_nxt = 1'b1;
                  state_nxt = GEN;
               end
            end
         end
         default: ;
      endcase
      // A load while a block is in flight waits for that block and discards it;
      // if its done is being consumed right now, restart immediately instead.
      if (load) begin
         state_nxt = GEN;
         ks_load   = 1'b0;
         if (state == GEN && !blk_done) begin
            pending_nxt = 1'b1;
            start_nxt   = 1'b0;
         end else begin
            pending_nxt = 1'b0;
            start_nxt   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ks        <= '0;
         key_r     <= '0;
         nonce_r   <= '0;
         ctr       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         ctr_err   <= 1'b0;
      end else begin
         if (ks_load) ks <= blk_out;
         if (in_xfer) begin
            out_data  <= in_data ^ ks[idx];
            out_valid <= 1'b1;
         end else if (out_xfer) begin
            out_valid <= 1'b0;
         end
         if (load) begin
            key_r   <= key;
            nonce_r <= nonce;
            ctr     <= ctr_init;
            idx     <= '0;
            ctr_err <= 1'b0;
         end else begin
            if (in_xfer) idx <= idx + 4'd1;
            if (ctr_inc) ctr <= ctr + 32'd1;
            if (err_set) ctr_err <= 1'b1;
         end
      end
   end

`ifdef CHACHA20_STREAM_WORD_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        word_cnt <= '0;
      else if (load)     word_cnt <= '0;
      else if (out_xfer) word_cnt <= word_cnt + 64'd1;
   end
`endif

endmodule

// File: tb/tb_chacha20_stream.sv
// Self-checking bench for chacha20_stream: reference ChaCha20 keystream model,
// per-cycle output/handshake checker, directed scenarios and a randomized phase.
module tb_chacha20_stream;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] key = '0;
   logic [95:0]  nonce = '0;
   logic [31:0]  ctr_init = '0;
   logic         load = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;
   logic         busy;
   logic         ctr_err;
`ifdef CHACHA20_STREAM_WORD_CNT_EN
   logic [63:0]  word_cnt;
`endif

   chacha20_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key),
      .nonce     (nonce),
      .ctr_init  (ctr_init),
      .load      (load),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .ctr_err   (ctr_err)
`ifdef CHACHA20_STREAM_WORD_CNT_EN
      ,
      .word_cnt  (word_cnt)
`endif
   );

   initial forever #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ChaCha20 block function, straight from the published algorithm.
   function automatic logic [31:0] rol(input logic [31:0] v, input int s);
      return (v << s) | (v >> (32 - s));
   endfunction

   function automatic logic [15:0][31:0] qr(input logic [15:0][31:0] x, input int a, input int b,
                                            input int c, input int d);
      x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 16);
      x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 12);
      x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 8);
      x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 7);
      return x;
   endfunction

   function automatic logic [31:0] ks_word(input logic [255:0] k, input logic [95:0] n,
                                           input logic [31:0] c, input int unsigned w);
      logic [15:0][31:0] s, x;
      s[0] = 32'h61707865;
      s[1] = 32'h3320646e;
      s[2] = 32'h79622d32;
      s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
      s[12] = c;
      for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
      x = s;
      for (int r = 0; r < 10; r++) begin
         x = qr(x, 0, 4, 8, 12);
         x = qr(x, 1, 5, 9, 13);
         x = qr(x, 2, 6, 10, 14);
         x = qr(x, 3, 7, 11, 15);
         x = qr(x, 0, 5, 10, 15);
         x = qr(x, 1, 6, 11, 12);
         x = qr(x, 2, 7, 8, 13);
         x = qr(x, 3, 4, 9, 14);
      end
      return x[w] + s[w];
   endfunction

   // Session model: words consumed since load select block counter and word.
   logic [31:0]  exp_q[$];
   logic [255:0] m_key = '0;
   logic [95:0]  m_nonce = '0;
   logic [31:0]  m_ctr0 = '0;
   int unsigned  m_k = 0;
   bit           m_busy = 0;
   bit           m_err = 0;
   bit           prev_hold = 0;
   logic [31:0]  prev_data = '0;

   initial begin
      logic [31:0] e, blk;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_busy    = 0;
            m_err     = 0;
            prev_hold = 0;
         end else begin
            if (prev_hold) chk(out_valid && out_data == prev_data, "hold_stable", out_data, prev_data);
            chk(busy == m_busy, "busy", busy, m_busy);
            chk(ctr_err == m_err, "ctr_err", ctr_err, m_err);
            if (!m_busy) chk(!in_ready, "in_ready_inactive", in_ready, 0);
            if (out_valid && out_ready) begin
               chk(exp_q.size() != 0, "out_unexpected", out_data, 0);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk(out_data == e, "out_data", out_data, e);
               end
            end
            if (in_valid && in_ready) begin
               blk = m_ctr0 + m_k / 16;
               exp_q.push_back(in_data ^ ks_word(m_key, m_nonce, blk, m_k % 16));
               if (m_k % 16 == 15 && blk == 32'hFFFFFFFF) begin
                  m_busy = 0;
                  m_err  = 1;
               end
               m_k++;
            end
            if (load) begin
               m_key   = key;
               m_nonce = nonce;
               m_ctr0  = ctr_init;
               m_k     = 0;
               m_busy  = 1;
               m_err   = 0;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
         end
      end
   end

   bit rnd_ready = 0;
   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
      key      = k;
      nonce    = n;
      ctr_init = c;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d);
      int unsigned n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk(in_ready, "in_ready_timeout", in_ready, 1);
            break;
         end
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n;
      n         = 0;
      out_ready = 1'b1;
      while ((out_valid || exp_q.size() != 0) && n < 100) begin
         step();
         n++;
      end
      chk(!out_valid && exp_q.size() == 0, "drain", {out_valid, 31'(exp_q.size())}, 0);
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [95:0] rand96();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      logic [255:0]     rfc_key;
      logic [95:0]      rfc_nonce;
      logic [8*114-1:0] pt;
      logic [31:0]      w, held;
      int unsigned      b;

      for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
      rfc_nonce = {32'h00000000, 32'h4a000000, 32'h00000000};
      pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
      chk(out_data == 32'h0, "rst_out_data", out_data, 0);
      chk(busy == 1'b0, "rst_busy", busy, 0);
      chk(ctr_err == 1'b0, "rst_ctr_err", ctr_err, 0);
      chk(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
      step();
      rst_n = 1'b1;
      step();

      // Pin the model against the first RFC 8439 keystream word
      w = ks_word(rfc_key, rfc_nonce, 32'd1, 0);
      chk(w == 32'hf3514f22, "model_rfc_ks0", w, 32'hf3514f22);

      // RFC vector plus a second block, out_ready held high
      do_load(rfc_key, rfc_nonce, 32'd1);
      for (int m = 0; m < 32; m++) begin
         w = $urandom();
         if (m < 29) begin
            for (int k = 0; k < 4; k++) begin
               b = 4 * m + k;
               w[8*k +: 8] = (b < 114) ? pt[8*(113-b) +: 8] : 8'h00;
            end
         end
         send_word(w);
         if (m == 0) begin
            @(negedge clk);
            chk(out_valid && out_data == 32'h9a352e6e, "rfc_word0", out_data, 32'h9a352e6e);
            step();
         end
         if (m == 15) begin
            @(negedge clk);
            chk(!in_ready && busy, "in_ready_gen", {in_ready, busy}, 2'b01);
            step();
         end
      end
      drain();

      // Backpressure: one word held for five cycles
      out_ready = 1'b0;
      send_word($urandom());
      @(negedge clk);
      held = out_data;
      for (int c = 0; c < 5; c++) begin
         chk(out_valid && out_data == held && !in_ready, "backpressure_hold",
             {out_valid, in_ready, out_data}, {2'b10, held});
         @(negedge clk);
      end
      step();
      out_ready = 1'b1;
      for (int m = 0; m < 10; m++) send_word($urandom());
      drain();

      // Counter exhaustion, then recovery by load
      do_load(rand256(), rand96(), 32'hFFFFFFFF);
      for (int m = 0; m < 16; m++) send_word($urandom());
      @(negedge clk);
      chk(ctr_err && !in_ready && !busy, "halt_state", {ctr_err, in_ready, busy}, 3'b100);
      repeat (4) step();
      drain();
      do_load(rand256(), rand96(), 32'd5);
      @(negedge clk);
      chk(!ctr_err && busy, "halt_reload", {ctr_err, busy}, 2'b01);
      step();
      for (int m = 0; m < 3; m++) send_word($urandom());
      drain();

      // Load while a block is in flight: new key must win
      do_load(rand256(), rand96(), $urandom());
      step();
      do_load(rfc_key, rfc_nonce, 32'd1);
      send_word(32'h6964614c);
      @(negedge clk);
      chk(out_valid && out_data == 32'h9a352e6e, "gen_reload_word0", out_data, 32'h9a352e6e);
      step();

      // Load coinciding with an input transfer
      key      = rand256();
      nonce    = rand96();
      ctr_init = $urandom();
      in_data  = $urandom();
      in_valid = 1'b1;
      load     = 1'b1;
      step();
      in_valid = 1'b0;
      load     = 1'b0;
      for (int m = 0; m < 3; m++) send_word($urandom());
      drain();

      // Randomized sessions with random backpressure and occasional reloads
      for (int s = 0; s < 3; s++) begin
         do_load(rand256(), rand96(), $urandom_range(0, 32'hFFFF0000));
         rnd_ready = 1;
         for (int m = 0; m < 40; m++) begin
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 15) == 0) do_load(rand256(), rand96(), $urandom_range(0, 32'hFFFF0000));
            send_word($urandom());
         end
         rnd_ready = 0;
         step();
         drain();
      end

      // Reset in the middle of block generation
      do_load(rand256(), rand96(), $urandom());
      repeat (3) step();
      rst_n = 1'b0;
      @(negedge clk);
      chk(!out_valid && out_data == 32'h0 && !busy && !ctr_err && !in_ready, "midgen_reset",
          {out_valid, busy, ctr_err, in_ready, out_data}, 0);
      step();
      rst_n = 1'b1;
      repeat (30) step();
      @(negedge clk);
      chk(!busy && !in_ready && !out_valid, "late_done_ignored", {busy, in_ready, out_valid}, 0);
      step();
      do_load(rfc_key, rfc_nonce, 32'd1);
      send_word(32'h6964614c);
      @(negedge clk);
      chk(out_valid && out_data == 32'h9a352e6e, "post_reset_word0", out_data, 32'h9a352e6e);
      step();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
